// File: rtl/cal_seq_pkg.sv
// Shared state encoding, calibration code table and sizing helpers
// for the DAC output calibration sequencer.
package cal_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        ACCUM,
        EMIT,
        DONE
    } state_t;

    localparam int NUM_CAL_POINTS = 4;
    localparam int CODE_W = 16;
    localparam int PT_W = $clog2(NUM_CAL_POINTS);

    // Entry 0 sits in the low bits; no entry may be 0 (0 means "not forcing").
    localparam logic [NUM_CAL_POINTS-1:0][CODE_W-1:0] CAL_POINTS = {
        16'sd20000,
        16'sd10000,
        -16'sd10000,
        -16'sd20000
    };

    function automatic logic signed [CODE_W-1:0] cal_code(
        input logic [PT_W-1:0] idx
    );
        return signed'(CAL_POINTS[idx]);
    endfunction

    function automatic int acc_width(input int w, input int log2n);
        return w + log2n;
    endfunction

endpackage

// File: rtl/output_cal_sequencer_sample_averager.sv
// Four-channel signed accumulator with clear, accumulate and
// floor-average latch.
module sample_averager
    import cal_seq_pkg::*;
#(
    parameter int W = 16,
    parameter int AVG_LOG2 = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              acc_en,
    input  logic              latch,
    input  logic [3:0][W-1:0] sample,
    output logic [3:0][W-1:0] avg
);

    localparam int AW = acc_width(W, AVG_LOG2);

    logic signed [AW-1:0] acc [4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < 4; c++) begin
                acc[c] <= '0;
                avg[c] <= '0;
            end
        end else begin
            for (int c = 0; c < 4; c++) begin
                if (clr) begin
                    acc[c] <= '0;
                end else if (acc_en) begin
                    acc[c] <= acc[c] + AW'(signed'(sample[c]));
                end
                if (latch) begin
                    avg[c] <= W'(acc[c] >>> AVG_LOG2);
                end
            end
        end
    end

endmodule

// File: rtl/output_cal_sequencer.sv
// Steps the DAC through the calibration codes, settles, averages the
// looped-back ADC channels and streams one result per point and channel.
module output_cal_sequencer
    import cal_seq_pkg::*;
#(
    parameter int W = 16,
    parameter int N_POINTS = NUM_CAL_POINTS,
    parameter int SETTLE_SAMPLES = 256,
    parameter int AVG_LOG2 = 6
) (
    input  logic                        clk_256fs,
    input  logic                        rst,
    input  logic                        clk_fs,
    input  logic                        start,
    input  logic                        abort,
    input  logic signed [W-1:0]         sample_adc0,
    input  logic signed [W-1:0]         sample_adc1,
    input  logic signed [W-1:0]         sample_adc2,
    input  logic signed [W-1:0]         sample_adc3,
    output logic signed [W-1:0]         force_dac_output,
    output logic                        busy,
    output logic                        done,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [$clog2(N_POINTS)-1:0] res_point,
    output logic [1:0]                  res_ch,
    output logic signed [W-1:0]         res_value
);

    localparam int AVG_N = 2 ** AVG_LOG2;
    localparam int CNT_MAX = SETTLE_SAMPLES > AVG_N ? SETTLE_SAMPLES : AVG_N;
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam int PW = $clog2(N_POINTS);

    state_t          state;
    logic            clk_fs_q;
    logic            strb;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   next_point;
    logic            settle_end;
    logic            accum_end;
    logic [3:0][W-1:0] avg;

    assign strb       = clk_fs & ~clk_fs_q;
    assign settle_end = cnt == CW'(SETTLE_SAMPLES);
    assign accum_end  = cnt == CW'(AVG_N);
    assign next_point = res_point + 1'b1;
    assign res_value  = avg[res_ch];

    always_ff @(posedge clk_256fs or posedge rst) begin
        if (rst) begin
            clk_fs_q <= 1'b0;
        end else begin
            clk_fs_q <= clk_fs;
        end
    end

    sample_averager #(
        .W        (W),
        .AVG_LOG2 (AVG_LOG2)
    ) u_avg (
        .clk    (clk_256fs),
        .rst    (rst),
        .clr    (state == IDLE || state == SETTLE),
        .acc_en (state == ACCUM && strb && !accum_end),
        .latch  (state == ACCUM && accum_end),
        .sample ({sample_adc3, sample_adc2, sample_adc1, sample_adc0}),
        .avg    (avg)
    );

    always_ff @(posedge clk_256fs or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            cnt              <= '0;
            res_point        <= '0;
            res_ch           <= '0;
            force_dac_output <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            res_valid        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state            <= IDLE;
                cnt              <= '0;
                res_point        <= '0;
                res_ch           <= '0;
                force_dac_output <= '0;
                busy             <= 1'b0;
                res_valid        <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            state            <= SETTLE;
                            cnt              <= '0;
                            res_point        <= '0;
                            res_ch           <= '0;
                            force_dac_output <= W'(cal_code('0));
                            busy             <= 1'b1;
                        end
                    end
                    SETTLE: begin
                        if (settle_end) begin
                            state <= ACCUM;
                            cnt   <= '0;
                        end else if (strb) begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ACCUM: begin
                        if (accum_end) begin
                            state     <= EMIT;
                            cnt       <= '0;
                            res_ch    <= '0;
                            res_valid <= 1'b1;
                        end else if (strb) begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    EMIT: begin
                        if (res_ready) begin
                            if (res_ch == 2'd3) begin
                                res_valid <= 1'b0;
                                res_ch    <= '0;
                                if (res_point == PW'(N_POINTS - 1)) begin
                                    state            <= DONE;
                                    done             <= 1'b1;
                                    busy             <= 1'b0;
                                    force_dac_output <= '0;
                                end else begin
                                    state            <= SETTLE;
                                    res_point        <= next_point;
                                    force_dac_output <= W'(cal_code(next_point));
                                end
                            end else begin
                                res_ch <= res_ch + 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        state     <= IDLE;
                        res_point <= '0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_output_cal_sequencer.sv
// Scoreboard bench for output_cal_sequencer with a fast sample clock
// and short settle/average windows.
module tb_output_cal_sequencer;

    localparam int W = 16;
    localparam int SETTLE = 8;
    localparam int AL2 = 2;

    logic clk_256fs = 1'b0;
    logic rst = 1'b1;
    logic clk_fs = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic res_ready = 1'b0;
    logic signed [W-1:0] adc0 = '0, adc1 = '0, adc2 = '0, adc3 = '0;
    logic signed [W-1:0] force_dac_output;
    logic signed [W-1:0] res_value;
    logic busy, done, res_valid;
    logic [1:0] res_point, res_ch;

    typedef struct {
        int pt;
        int ch;
        int val;
        int frc;
    } exp_t;

    exp_t sb[$];
    int n_tests = 0;
    int n_fail = 0;
    int n_done = 0;
    int n_hs = 0;
    int mode = 0;
    int div = 0;
    int strb_idx = 0;
    int start_idx = 0;
    int cv[4] = '{0, 0, 0, 0};
    int ramp_base[4] = '{-3, 100, -8, 32764};
    int fc[4] = '{-20000, -10000, 10000, 20000};

    output_cal_sequencer #(
        .W              (W),
        .N_POINTS       (4),
        .SETTLE_SAMPLES (SETTLE),
        .AVG_LOG2       (AL2)
    ) dut (
        .clk_256fs        (clk_256fs),
        .rst              (rst),
        .clk_fs           (clk_fs),
        .start            (start),
        .abort            (abort),
        .sample_adc0      (adc0),
        .sample_adc1      (adc1),
        .sample_adc2      (adc2),
        .sample_adc3      (adc3),
        .force_dac_output (force_dac_output),
        .busy             (busy),
        .done             (done),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_point        (res_point),
        .res_ch           (res_ch),
        .res_value        (res_value)
    );

    always #5 clk_256fs = ~clk_256fs;

    function automatic int ramp_val(input int c, input int k);
        if (k >= 1 && k <= SETTLE) return 9999;
        if (k > SETTLE && k <= SETTLE + 4) return ramp_base[c] + k - SETTLE - 1;
        return 0;
    endfunction

    // Sample clock: rises on a falling edge, so the strobe lands on the next rising edge.
    always @(negedge clk_256fs) begin
        div = (div + 1) % 4;
        if (div == 0) begin
            clk_fs = 1'b1;
            strb_idx++;
        end else if (div == 2) begin
            clk_fs = 1'b0;
        end
        if (mode == 0) begin
            adc0 = W'(cv[0]);
            adc1 = W'(cv[1]);
            adc2 = W'(cv[2]);
            adc3 = W'(cv[3]);
        end else if (div == 0) begin
            adc0 = W'(ramp_val(0, strb_idx - start_idx));
            adc1 = W'(ramp_val(1, strb_idx - start_idx));
            adc2 = W'(ramp_val(2, strb_idx - start_idx));
            adc3 = W'(ramp_val(3, strb_idx - start_idx));
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_256fs);
        #1;
    endtask

    task automatic pulse_start();
        tick();
        start = 1'b1;
        start_idx = strb_idx;
        tick();
        start = 1'b0;
    endtask

    task automatic push_point(input int pt, input int v0, input int v1,
                              input int v2, input int v3);
        exp_t e;
        int v[4];
        v = '{v0, v1, v2, v3};
        for (int c = 0; c < 4; c++) begin
            e = '{pt, c, v[c], fc[pt]};
            sb.push_back(e);
        end
    endtask

    task automatic wait_idle(input string name);
        int i;
        i = 0;
        while (busy && i < 3000) begin
            tick();
            i++;
        end
        if (busy) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: busy still %0d, required 0", name, busy);
        end
    endtask

    task automatic wait_valid(input string name);
        int i;
        i = 0;
        while (!res_valid && i < 1000) begin
            tick();
            i++;
        end
        if (!res_valid) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: res_valid %0d, required 1", name, res_valid);
        end
    endtask

    task automatic finish_run(input string name, input int d0);
        wait_idle(name);
        tick();
        tick();
        chk({name, "_done_count"}, n_done - d0, 1);
        chk({name, "_left_in_sb"}, sb.size(), 0);
        chk({name, "_force_idle"}, force_dac_output, 0);
    endtask

    // Monitor: pops the scoreboard on every handshake and checks stall stability.
    int pv_ch, pv_pt, pv_val;
    logic stall_prev = 1'b0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_256fs);
            #2;
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                if (done) begin
                    n_done++;
                    chk("force_in_done", force_dac_output, 0);
                    chk("busy_in_done", busy, 0);
                end
                if (stall_prev) begin
                    chk("stall_valid", res_valid, 1);
                    chk("stall_ch", res_ch, pv_ch);
                    chk("stall_point", res_point, pv_pt);
                    chk("stall_value", res_value, pv_val);
                end
                if (res_valid && res_ready) begin
                    n_hs++;
                    if (sb.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_result: got pt %0d ch %0d val %0d, required none",
                                 res_point, res_ch, res_value);
                    end else begin
                        e = sb.pop_front();
                        chk("res_point", res_point, e.pt);
                        chk("res_ch", res_ch, e.ch);
                        chk("res_value", res_value, e.val);
                        chk("force_at_result", force_dac_output, e.frc);
                    end
                end
                stall_prev = res_valid && !res_ready;
                pv_ch = res_ch;
                pv_pt = res_point;
                pv_val = res_value;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1);
    end

    initial begin
        int d0;
        int h0;
        int i;

        repeat (3) tick();
        chk("rst_force", force_dac_output, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_point", res_point, 0);
        chk("rst_ch", res_ch, 0);
        chk("rst_value", res_value, 0);
        rst = 1'b0;
        tick();

        // Constant inputs, full sequence, with a stray start while busy.
        cv = '{1000, -1000, 0, 32767};
        res_ready = 1'b1;
        for (int p = 0; p < 4; p++) push_point(p, 1000, -1000, 0, 32767);
        d0 = n_done;
        pulse_start();
        chk("A_force_first", force_dac_output, -20000);
        chk("A_busy", busy, 1);
        repeat (20) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        finish_run("A", d0);

        // Ramp in the average window, spike in the settle window.
        mode = 1;
        push_point(0, -2, 101, -7, 32765);
        for (int p = 1; p < 4; p++) push_point(p, 0, 0, 0, 0);
        d0 = n_done;
        pulse_start();
        finish_run("B", d0);
        mode = 0;

        // Consumer stalls 50 cycles on the first result.
        cv = '{1234, -5678, 42, -1};
        res_ready = 1'b0;
        for (int p = 0; p < 4; p++) push_point(p, 1234, -5678, 42, -1);
        d0 = n_done;
        pulse_start();
        wait_valid("C");
        cv = '{7777, 7777, 7777, 7777};
        repeat (50) tick();
        cv = '{1234, -5678, 42, -1};
        res_ready = 1'b1;
        finish_run("C", d0);

        // Abort during the averaging window of point 2.
        cv = '{11, 22, 33, 44};
        push_point(0, 11, 22, 33, 44);
        push_point(1, 11, 22, 33, 44);
        d0 = n_done;
        h0 = n_hs;
        pulse_start();
        i = 0;
        while (n_hs < h0 + 8 && i < 1000) begin
            tick();
            i++;
        end
        chk("D_results_before_abort", n_hs - h0, 8);
        repeat (36) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("D_busy_after_abort", busy, 0);
        chk("D_force_after_abort", force_dac_output, 0);
        chk("D_valid_after_abort", res_valid, 0);
        repeat (20) tick();
        chk("D_no_done", n_done - d0, 0);
        chk("D_no_more_results", n_hs - h0, 8);
        chk("D_left_in_sb", sb.size(), 0);

        // Abort and start together: abort wins.
        tick();
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("E_busy_abort_start", busy, 0);
        chk("E_force_abort_start", force_dac_output, 0);
        repeat (5) tick();
        chk("E_still_idle", busy, 0);

        // Fresh run after abort starts from point 0 with clean accumulators.
        cv = '{-7, 7, -32768, 500};
        for (int p = 0; p < 4; p++) push_point(p, -7, 7, -32768, 500);
        d0 = n_done;
        pulse_start();
        chk("E_force_first", force_dac_output, -20000);
        finish_run("E", d0);

        // Asynchronous reset while a result is pending.
        cv = '{300, -300, 5, -5};
        res_ready = 1'b0;
        d0 = n_done;
        pulse_start();
        wait_valid("F");
        chk("F_value_ch0", res_value, 300);
        rst = 1'b1;
        #1;
        chk("F_rst_force", force_dac_output, 0);
        chk("F_rst_busy", busy, 0);
        chk("F_rst_valid", res_valid, 0);
        chk("F_rst_value", res_value, 0);
        chk("F_rst_point", res_point, 0);
        tick();
        rst = 1'b0;
        repeat (10) tick();
        chk("F_idle_after_rst", busy, 0);
        chk("F_no_done", n_done - d0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
